// File: rtl/uart_msg_sequencer.sv
// Byte-buffer message sequencer driving a UART transmitter over a valid/busy handshake.
// Define MSGSEQ_REPEAT_EN to add the repeatCount port and multi-pass playback.
module uart_msg_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned GAP_W  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [AW:0]       msgLen,
  input  logic [GAP_W-1:0]  gapCycles,
`ifdef MSGSEQ_REPEAT_EN
  input  logic [7:0]        repeatCount,
`endif
  input  logic              start,
  input  logic              abort,
  output logic [DATA_W-1:0] txData,
  output logic              txValid,
  input  logic              txBusy,
  output logic              active,
  output logic              done,
  output logic [AW-1:0]     bytePtr
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StGap, StAdv} stateT;

  localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneLen   = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  stateT             stateQ, stateD;
  logic [AW:0]       lenQ, lenD;
  logic [GAP_W-1:0]  gapQ, gapD;
  logic [GAP_W-1:0]  gapCntQ, gapCntD;
  logic [AW-1:0]     ptrQ, ptrD;
  logic [DATA_W-1:0] txDataQ, txDataD;
  logic              doneQ, doneD;
  logic              abortQ, abortD;
  logic              skipQ, skipD;
`ifdef MSGSEQ_REPEAT_EN
  logic [7:0]        passQ, passD;
`endif

  logic [AW:0] msgLenSat;
  logic        lastByte;

  assign msgLenSat = (msgLen > DepthLen) ? DepthLen : msgLen;
  assign lastByte  = ({1'b0, ptrQ} == (lenQ - OneLen));

  // Buffer contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ  <= StIdle;
      lenQ    <= '0;
      gapQ    <= '0;
      gapCntQ <= '0;
      ptrQ    <= '0;
      txDataQ <= '0;
      doneQ   <= 1'b0;
      abortQ  <= 1'b0;
      skipQ   <= 1'b0;
`ifdef MSGSEQ_REPEAT_EN
      passQ   <= '0;
`endif
    end else begin
      stateQ  <= stateD;
      lenQ    <= lenD;
      gapQ    <= gapD;
      gapCntQ <= gapCntD;
      ptrQ    <= ptrD;
      txDataQ <= txDataD;
      doneQ   <= doneD;
      abortQ  <= abortD;
      skipQ   <= skipD;
`ifdef MSGSEQ_REPEAT_EN
      passQ   <= passD;
`endif
    end
  end

  always_comb begin
    stateD  = stateQ;
    lenD    = lenQ;
    gapD    = gapQ;
    gapCntD = gapCntQ;
    ptrD    = ptrQ;
    txDataD = txDataQ;
    doneD   = 1'b0;
    abortD  = abortQ;
    skipD   = skipQ;
`ifdef MSGSEQ_REPEAT_EN
    passD   = passQ;
`endif
    if (abort && (stateQ != StIdle)) begin
      abortD = 1'b1;
    end
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          lenD   = msgLenSat;
          gapD   = gapCycles;
          ptrD   = '0;
          abortD = 1'b0;
`ifdef MSGSEQ_REPEAT_EN
          passD  = repeatCount;
`endif
          if (msgLenSat == '0) begin
            doneD = 1'b1;
          end else begin
            stateD = StLoad;
          end
        end
      end
      StLoad: begin
        // Latch now so a later write to this entry cannot change the byte in flight.
        txDataD = mem[ptrQ];
        stateD  = StIssue;
      end
      StIssue: begin
        if (!txBusy) begin
          skipD  = 1'b1;
          stateD = StWait;
        end
      end
      StWait: begin
        // First cycle after the strobe: txBusy has not risen yet.
        if (skipQ) begin
          skipD = 1'b0;
        end else if (!txBusy) begin
          if (gapQ != '0) begin
            gapCntD = gapQ;
            stateD  = StGap;
          end else begin
            stateD = StAdv;
          end
        end
      end
      StGap: begin
        gapCntD = gapCntQ - GAP_W'(1);
        if (gapCntQ == GAP_W'(1)) begin
          stateD = StAdv;
        end
      end
      StAdv: begin
        if (abortQ || abort) begin
          abortD = 1'b0;
          doneD  = 1'b1;
          stateD = StIdle;
        end else if (!lastByte) begin
          ptrD   = ptrQ + AW'(1);
          stateD = StLoad;
`ifdef MSGSEQ_REPEAT_EN
        end else if (passQ != '0) begin
          ptrD   = '0;
          passD  = passQ - 8'd1;
          stateD = StLoad;
`endif
        end else begin
          doneD  = 1'b1;
          stateD = StIdle;
        end
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_comb begin
    txValid = (stateQ == StIssue) && !txBusy;
    active  = (stateQ != StIdle);
  end

  assign txData  = txDataQ;
  assign done    = doneQ;
  assign bytePtr = ptrQ;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Scoreboard bench for uart_msg_sequencer with a simple busy-counting UART model.
module tb_uart_msg_sequencer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int GAP_W  = 16;
  localparam int AW     = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wrEn = 1'b0;
  logic [AW-1:0]     wrAddr = '0;
  logic [DATA_W-1:0] wrData = '0;
  logic [AW:0]       msgLen = '0;
  logic [GAP_W-1:0]  gapCycles = '0;
`ifdef MSGSEQ_REPEAT_EN
  logic [7:0]        repeatCount = '0;
`endif
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] txData;
  logic              txValid;
  logic              txBusy;
  logic              active;
  logic              done;
  logic [AW-1:0]     bytePtr;

  uart_msg_sequencer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .GAP_W (GAP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .msgLen     (msgLen),
    .gapCycles  (gapCycles),
`ifdef MSGSEQ_REPEAT_EN
    .repeatCount(repeatCount),
`endif
    .start      (start),
    .abort      (abort),
    .txData     (txData),
    .txValid    (txValid),
    .txBusy     (txBusy),
    .active     (active),
    .done       (done),
    .bytePtr    (bytePtr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART model: busy for busyLen cycles starting the cycle after an accepted strobe.
  int busyLen = 10;
  int busyCnt;
  always @(posedge clk or posedge reset) begin
    if (reset) busyCnt <= 0;
    else if (txValid && !txBusy) busyCnt <= busyLen;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign txBusy = (busyCnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbQ[$];
  logic [7:0] expBuf[DEPTH];
  int validCycQ[$];
  int validCnt = 0;
  int doneCnt = 0;
  int doneCyc = 0;
  int activeCnt = 0;
  int wraps = 0;
  logic prevActive = 1'b0;
  logic [AW-1:0] prevPtr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (txValid) begin
        validCnt++;
        validCycQ.push_back(cyc);
        if (sbQ.size() == 0) checkVal("sb_underflow", sbQ.size(), 1);
        else checkVal("tx_data", txData, sbQ.pop_front());
      end
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (active) activeCnt++;
      if (active && prevActive && bytePtr == '0 && prevPtr != '0) wraps++;
      prevActive = active;
      prevPtr = bytePtr;
    end
  end

  int startCyc;

  task automatic writeBuf(input int a, input logic [7:0] d);
    @(negedge clk);
    wrEn = 1'b1;
    wrAddr = a[AW-1:0];
    wrData = d;
    expBuf[a] = d;
    @(posedge clk);
    #1 wrEn = 1'b0;
  endtask

  task automatic startMsg(input int len, input int gap, input int rep, input bit withAbort);
    @(negedge clk);
    msgLen = (AW+1)'(len);
    gapCycles = GAP_W'(gap);
`ifdef MSGSEQ_REPEAT_EN
    repeatCount = 8'(rep);
`else
    if (rep != 0) $display("note: repeat ignored without MSGSEQ_REPEAT_EN");
`endif
    start = 1'b1;
    abort = withAbort;
    startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pushExp(input int n);
    for (int i = 0; i < n; i++) sbQ.push_back(expBuf[i]);
  endtask

  task automatic waitDone(input int bound, input string tag);
    int base = doneCnt;
    int n = 0;
    while (doneCnt == base && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (doneCnt == base) checkVal({tag, "_timeout"}, doneCnt - base, 1);
  endtask

  task automatic waitValid(input int target, input int bound, input string tag);
    int n = 0;
    while (validCnt < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (validCnt < target) checkVal({tag, "_timeout"}, validCnt, target);
  endtask

  int vb, db, ab, wb;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_txValid", txValid, 0);
    checkVal("rst_active", active, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_bytePtr", bytePtr, 0);
    checkVal("rst_txData", txData, 0);
    reset = 1'b0;

    // "hi\n", gap 0, busy 10
    writeBuf(0, 8'h68);
    writeBuf(1, 8'h69);
    writeBuf(2, 8'h0A);
    busyLen = 10;
    vb = validCnt; db = doneCnt;
    pushExp(3);
    startMsg(3, 0, 0, 0);
    waitDone(200, "hi");
    checkVal("hi_count", validCnt - vb, 3);
    checkVal("hi_done", doneCnt - db, 1);
    // start cycle, LOAD cycle, then the ISSUE cycle carries txValid
    if (validCnt - vb >= 2) begin
      checkVal("hi_latency", validCycQ[vb] - startCyc, 2);
      checkVal("hi_spacing", validCycQ[vb+1] - validCycQ[vb], 10 + 1 + 0 + 3);
    end
    @(negedge clk);
    checkVal("hi_active_end", active, 0);
    checkVal("hi_sb_empty", sbQ.size(), 0);

    // zero-length message
    vb = validCnt; db = doneCnt; ab = activeCnt;
    startMsg(0, 0, 0, 0);
    waitDone(10, "len0");
    checkVal("len0_done_cyc", doneCyc - startCyc, 1);
    checkVal("len0_no_valid", validCnt - vb, 0);
    checkVal("len0_no_active", activeCnt - ab, 0);

    // gap 5, two bytes, busy 10
    writeBuf(0, 8'h31);
    writeBuf(1, 8'h32);
    vb = validCnt;
    pushExp(2);
    startMsg(2, 5, 0, 0);
    waitDone(200, "gap");
    checkVal("gap_count", validCnt - vb, 2);
    if (validCnt - vb >= 2) checkVal("gap_spacing", validCycQ[vb+1] - validCycQ[vb], 19);

    // oversize length saturates to DEPTH
    for (int i = 0; i < DEPTH; i++) writeBuf(i, 8'(i * 3 + 1));
    busyLen = 1;
    vb = validCnt;
    pushExp(DEPTH);
    startMsg(100, 0, 0, 0);
    waitDone(2000, "sat");
    checkVal("sat_count", validCnt - vb, DEPTH);
    checkVal("sat_ptr", bytePtr, DEPTH - 1);

    // start and abort in the same idle cycle: abort is discarded
    vb = validCnt;
    pushExp(2);
    startMsg(2, 0, 0, 1);
    waitDone(200, "sa");
    checkVal("sa_count", validCnt - vb, 2);

    // abort while byte 4 of 10 is in flight
    busyLen = 10;
    vb = validCnt; db = doneCnt;
    pushExp(10);
    startMsg(10, 0, 0, 0);
    waitValid(vb + 5, 500, "abort_wait");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waitDone(200, "abort");
    checkVal("abort_count", validCnt - vb, 5);
    checkVal("abort_done", doneCnt - db, 1);
    @(negedge clk);
    checkVal("abort_active", active, 0);
    checkVal("abort_left", sbQ.size(), 5);
    sbQ.delete();

    // reset in WAIT, then restart from byte 0
    vb = validCnt;
    pushExp(3);
    startMsg(3, 0, 0, 0);
    waitValid(vb + 1, 100, "rstw_wait");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkVal("rstw_txValid", txValid, 0);
    checkVal("rstw_active", active, 0);
    checkVal("rstw_bytePtr", bytePtr, 0);
    checkVal("rstw_txData", txData, 0);
    checkVal("rstw_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    sbQ.delete();
    db = doneCnt;
    repeat (3) @(posedge clk);
    checkVal("rstw_no_done", doneCnt - db, 0);
    vb = validCnt;
    pushExp(2);
    startMsg(2, 0, 0, 0);
    waitDone(200, "rstw_again");
    checkVal("rstw_again_count", validCnt - vb, 2);
    if (validCnt - vb >= 1) checkVal("rstw_again_latency", validCycQ[vb] - startCyc, 2);

`ifdef MSGSEQ_REPEAT_EN
    // 34 bytes of 0x0A, two extra passes
    for (int i = 0; i < 34; i++) writeBuf(i, 8'h0A);
    busyLen = 2;
    vb = validCnt; db = doneCnt; wb = wraps;
    for (int p = 0; p < 3; p++) pushExp(34);
    startMsg(34, 0, 2, 0);
    waitDone(5000, "rep");
    checkVal("rep_count", validCnt - vb, 102);
    checkVal("rep_wraps", wraps - wb, 2);
    checkVal("rep_done", doneCnt - db, 1);
`endif

    repeat (2) @(posedge clk);
    checkVal("final_sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
